display_arbiter: RTL and testbench
==================================

// Module: display_arbiter
// PURPOSE
//  Owns the seven-segment Display inputs (Digits/DispMode/Valid) and shares them between three
//  sources: keypad entry echo (background), timed status messages, and alarm (highest priority).
//  Sits between the security FSM/keypad logic and Display, on the 1 kHz clkdiv clock.
//  Sequences message hold time and alarm blink, and drives the buzzer enable.
// PARAMETERS
//  MSG_HOLD    2000   cycles a status message stays on screen (>=2; 2 s at 1 kHz)
//  ALARM_BLINK 250    cycles per alarm blink phase (>=1)
//  ALARM_MODE  2'b10  DispMode driven while alarm owns the display
//  CNT_W       12     width of hold/blink counters; must hold MSG_HOLD-1 and ALARM_BLINK-1
// PORTS
//  clk           in   1   system clock (1 kHz from clkdiv)
//  reset         in   1   synchronous, active-low reset
//  entry_digits  in   16  keypad echo digits, 4 BCD/hex nibbles
//  entry_valid   in   4   keypad echo digit enables
//  msg_req       in   1   status message request; held high until msg_ack
//  msg_digits    in   16  message digits, sampled on acceptance
//  msg_mode      in   2   message DispMode, sampled on acceptance
//  msg_valid     in   4   message digit enables, sampled on acceptance
//  msg_ack       out  1   one-cycle pulse: message accepted
//  alarm_req     in   1   level; alarm display while high
//  alarm_digits  in   16  alarm digits (live, not latched)
//  alarm_valid   in   4   alarm digit enables during on-phase
//  Digits        out  16  to Display.Digits
//  DispMode      out  2   to Display.DispMode
//  Valid         out  4   to Display.Valid
//  owner         out  2   0=entry 1=message 2=alarm
//  buzz          out  1   buzzer enable
// BEHAVIOUR
//  - All outputs registered; reset (reset==0 at posedge) forces state IDLE, counters 0, Digits=0,
//    DispMode=0, Valid=0, msg_ack=0, owner=0, buzz=0, message latch cleared. Reset mid-MSG/ALARM
//    abandons it; no ack is issued.
//  - States: IDLE, MSG, ALARM. Outputs reflect the new state the cycle after the deciding input.
//  - IDLE: Digits=entry_digits, Valid=entry_valid, DispMode=0, owner=0 (1-cycle latency).
//  - Priority each cycle: alarm_req > msg_req > current state.
//  - Any state, alarm_req=1 -> ALARM; blink cnt=0, phase=on. Active MSG is discarded, not resumed.
//  - ALARM: Digits=alarm_digits, DispMode=ALARM_MODE, owner=2, buzz=1; Valid=alarm_valid when
//    phase=on, 4'b0000 when off; phase toggles every ALARM_BLINK cycles (cnt wraps to 0).
//    alarm_req=0 -> IDLE (buzz=0 next cycle).
//  - Acceptance: msg_req=1, alarm_req=0, msg_ack currently 0 -> latch msg_digits/mode/valid,
//    msg_ack=1 for exactly one cycle, state MSG, hold cnt=0. While msg_ack=1, msg_req ignored.
//  - MSG: outputs = latched message, owner=1. Accepted msg_req in MSG retriggers: re-latch,
//    ack, cnt=0. Message displayed exactly MSG_HOLD cycles, then IDLE (cnt==MSG_HOLD-1 -> IDLE).
//  - msg_req during ALARM is not acked; it waits (requester holds req) and is accepted the
//    cycle alarm_req falls, i.e. ALARM -> MSG directly.
//  - Simultaneous alarm_req and msg_req: alarm wins, no ack.
//  - Counters saturate-free: wrap only as specified; never exceed CNT_W.
// TESTING (bench uses MSG_HOLD=4, ALARM_BLINK=2)
//  1. reset=0 3 cycles, then 1 with entry_digits=16'h1234, entry_valid=4'b0011 -> all outputs 0
//     during reset; next cycle Digits=16'h1234, Valid=4'b0011, DispMode=0, owner=0.
//  2. msg_req with msg_digits=16'hC0DE, msg_valid=4'hF, msg_mode=2'b01 -> msg_ack 1 cycle,
//     Digits=16'hC0DE, DispMode=01, owner=1 for exactly 4 cycles, then entry digits return.
//  3. Second msg_req (16'hBEEF) in MSG hold cycle 3 -> new ack, BEEF shown full 4 cycles.
//  4. alarm_req=1 during MSG, alarm_digits=16'hAAAA, alarm_valid=4'hF -> next cycle owner=2,
//    buzz=1, Valid sequence F,F,0,0,F,F; drop alarm -> IDLE, message not resumed, buzz=0.
//  5. msg_req and alarm_req raised same cycle -> no ack while alarm high; alarm drops -> ack
//     that cycle, MSG shown 4 cycles.
//  6. reset=0 in MSG hold cycle 2 -> next cycle all outputs 0, state IDLE, no msg_ack.

Source files
------------

// File: rtl/display_arbiter.sv
// Shares the seven-segment display between keypad echo, timed status messages and the alarm.
// Alarm has top priority, then message requests; all display outputs are registered.
module display_arbiter #(
    parameter int          MSG_HOLD    = 2000,
    parameter int          ALARM_BLINK = 250,
    parameter logic [1:0]  ALARM_MODE  = 2'b10,
    parameter int          CNT_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] entry_digits,
    input  logic [3:0]  entry_valid,
    input  logic        msg_req,
    input  logic [15:0] msg_digits,
    input  logic [1:0]  msg_mode,
    input  logic [3:0]  msg_valid,
    output logic        msg_ack,
    input  logic        alarm_req,
    input  logic [15:0] alarm_digits,
    input  logic [3:0]  alarm_valid,
    output logic [15:0] Digits,
    output logic [1:0]  DispMode,
    output logic [3:0]  Valid,
    output logic [1:0]  owner,
    output logic        buzz
);

    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_MSG     = 2'd1;
    localparam logic [1:0]       ST_ALARM   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MSG_HOLD - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(ALARM_BLINK - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             phase_q,  phase_d;
    logic [15:0]      mdig_q,   mdig_d;
    logic [1:0]       mmode_q,  mmode_d;
    logic [3:0]       mvalid_q, mvalid_d;
    logic             ack_q,    ack_d;
    logic [15:0]      digits_q, digits_d;
    logic [1:0]       mode_q,   mode_d;
    logic [3:0]       valid_q,  valid_d;
    logic [1:0]       owner_q,  owner_d;
    logic             buzz_q,   buzz_d;

    // Next-state: alarm preempts, then message acceptance, then the current state's own sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        mdig_d   = mdig_q;
        mmode_d  = mmode_q;
        mvalid_d = mvalid_q;
        ack_d    = 1'b0;
        if (alarm_req) begin
            state_d = ST_ALARM;
            if (state_q != ST_ALARM) begin
                cnt_d   = CNT_ZERO;
                phase_d = 1'b1;
            end else if (cnt_q == BLINK_LAST) begin
                cnt_d   = CNT_ZERO;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
            end
        end else if (msg_req && !ack_q) begin
            state_d  = ST_MSG;
            cnt_d    = CNT_ZERO;
            mdig_d   = msg_digits;
            mmode_d  = msg_mode;
            mvalid_d = msg_valid;
            ack_d    = 1'b1;
        end else begin
            case (state_q)
                ST_MSG: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                ST_ALARM: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    phase_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the display changes together with ownership.
    always_comb begin
        digits_d = entry_digits;
        mode_d   = 2'b00;
        valid_d  = entry_valid;
        owner_d  = 2'd0;
        buzz_d   = 1'b0;
        case (state_d)
            ST_MSG: begin
                digits_d = mdig_d;
                mode_d   = mmode_d;
                valid_d  = mvalid_d;
                owner_d  = 2'd1;
            end
            ST_ALARM: begin
                digits_d = alarm_digits;
                mode_d   = ALARM_MODE;
                valid_d  = phase_d ? alarm_valid : 4'b0000;
                owner_d  = 2'd2;
                buzz_d   = 1'b1;
            end
            default: begin
                digits_d = entry_digits;
                mode_d   = 2'b00;
                valid_d  = entry_valid;
                owner_d  = 2'd0;
                buzz_d   = 1'b0;
            end
        endcase
    end

    // State, message latch and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            phase_q  <= 1'b0;
            mdig_q   <= 16'h0000;
            mmode_q  <= 2'b00;
            mvalid_q <= 4'b0000;
            ack_q    <= 1'b0;
            digits_q <= 16'h0000;
            mode_q   <= 2'b00;
            valid_q  <= 4'b0000;
            owner_q  <= 2'd0;
            buzz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            mdig_q   <= mdig_d;
            mmode_q  <= mmode_d;
            mvalid_q <= mvalid_d;
            ack_q    <= ack_d;
            digits_q <= digits_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            buzz_q   <= buzz_d;
        end
    end

    assign msg_ack  = ack_q;
    assign Digits   = digits_q;
    assign DispMode = mode_q;
    assign Valid    = valid_q;
    assign owner    = owner_q;
    assign buzz     = buzz_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter with MSG_HOLD=4, ALARM_BLINK=2.
module tb_display_arbiter;

    typedef struct packed {
        logic [15:0] digits;
        logic [1:0]  mode;
        logic [3:0]  valid;
        logic        ack;
        logic [1:0]  owner;
        logic        buzz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] entry_digits = 16'h0000;
    logic [3:0]  entry_valid = 4'b0000;
    logic        msg_req = 1'b0;
    logic [15:0] msg_digits = 16'h0000;
    logic [1:0]  msg_mode = 2'b00;
    logic [3:0]  msg_valid = 4'b0000;
    logic        msg_ack;
    logic        alarm_req = 1'b0;
    logic [15:0] alarm_digits = 16'h0000;
    logic [3:0]  alarm_valid = 4'b0000;
    logic [15:0] Digits;
    logic [1:0]  DispMode;
    logic [3:0]  Valid;
    logic [1:0]  owner;
    logic        buzz;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t obs_q[$];

    display_arbiter #(.MSG_HOLD(4), .ALARM_BLINK(2), .ALARM_MODE(2'b10), .CNT_W(12)) dut (
        .clk(clk), .reset(reset),
        .entry_digits(entry_digits), .entry_valid(entry_valid),
        .msg_req(msg_req), .msg_digits(msg_digits), .msg_mode(msg_mode), .msg_valid(msg_valid),
        .msg_ack(msg_ack),
        .alarm_req(alarm_req), .alarm_digits(alarm_digits), .alarm_valid(alarm_valid),
        .Digits(Digits), .DispMode(DispMode), .Valid(Valid), .owner(owner), .buzz(buzz)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] d, input logic [1:0] m, input logic [3:0] v,
                                input logic a, input logic [1:0] o, input logic b);
        exp_t e;
        e.digits = d; e.mode = m; e.valid = v; e.ack = a; e.owner = o; e.buzz = b;
        return e;
    endfunction

    // Push the expected outputs for the coming edge, clock once, record what the DUT shows.
    task automatic step(input exp_t e);
        exp_t o;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.digits = Digits; o.mode = DispMode; o.valid = Valid;
        o.ack = msg_ack; o.owner = owner; o.buzz = buzz;
        obs_q.push_back(o);
    endtask

    task automatic test_reset;
        exp_t e, o;
        int n = 0;
        reset = 1'b0;
        entry_digits = 16'h1234;
        entry_valid = 4'b0011;
        for (int i = 0; i < 3; i++) step(mk(16'h0000, 2'b00, 4'b0000, 1'b0, 2'd0, 1'b0));
        reset = 1'b1;
        step(mk(16'h1234, 2'b00, 4'b0011, 1'b0, 2'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL test_reset[%0d] got=%h want=%h (digits,mode,valid,ack,owner,buzz)", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_msg;
        exp_t e, o;
        int n = 0;
        msg_req = 1'b1; msg_digits = 16'hC0DE; msg_mode = 2'b01; msg_valid = 4'hF;
        step(mk(16'hC0DE, 2'b01, 4'hF, 1'b1, 2'd1, 1'b0));
        msg_req = 1'b0; msg_digits = 16'h0000; msg_mode = 2'b00; msg_valid = 4'h0;
        for (int i = 0; i < 3; i++) step(mk(16'hC0DE, 2'b01, 4'hF, 1'b0, 2'd1, 1'b0));
        step(mk(16'h1234, 2'b00, 4'b0011, 1'b0, 2'd0, 1'b0));
        entry_digits = 16'h5678; entry_valid = 4'hF;
        step(mk(16'h5678, 2'b00, 4'hF, 1'b0, 2'd0, 1'b0));
        entry_digits = 16'h1234; entry_valid = 4'b0011;
        step(mk(16'h1234, 2'b00, 4'b0011, 1'b0, 2'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL test_msg[%0d] got=%h want=%h (digits,mode,valid,ack,owner,buzz)", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_retrigger;
        exp_t e, o;
        int n = 0;
        msg_req = 1'b1; msg_digits = 16'hC0DE; msg_mode = 2'b01; msg_valid = 4'hF;
        step(mk(16'hC0DE, 2'b01, 4'hF, 1'b1, 2'd1, 1'b0));
        msg_req = 1'b0;
        for (int i = 0; i < 2; i++) step(mk(16'hC0DE, 2'b01, 4'hF, 1'b0, 2'd1, 1'b0));
        msg_req = 1'b1; msg_digits = 16'hBEEF; msg_mode = 2'b11; msg_valid = 4'b1010;
        step(mk(16'hBEEF, 2'b11, 4'b1010, 1'b1, 2'd1, 1'b0));
        msg_req = 1'b0;
        for (int i = 0; i < 3; i++) step(mk(16'hBEEF, 2'b11, 4'b1010, 1'b0, 2'd1, 1'b0));
        step(mk(16'h1234, 2'b00, 4'b0011, 1'b0, 2'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL test_retrigger[%0d] got=%h want=%h (digits,mode,valid,ack,owner,buzz)", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_alarm;
        exp_t e, o;
        int n = 0;
        logic [3:0] vseq [6] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
        msg_req = 1'b1; msg_digits = 16'hC0DE; msg_mode = 2'b01; msg_valid = 4'hF;
        step(mk(16'hC0DE, 2'b01, 4'hF, 1'b1, 2'd1, 1'b0));
        msg_req = 1'b0;
        step(mk(16'hC0DE, 2'b01, 4'hF, 1'b0, 2'd1, 1'b0));
        alarm_req = 1'b1; alarm_digits = 16'hAAAA; alarm_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) alarm_digits = 16'h5555;
            step(mk((i >= 3) ? 16'h5555 : 16'hAAAA, 2'b10, vseq[i], 1'b0, 2'd2, 1'b1));
        end
        alarm_req = 1'b0;
        for (int i = 0; i < 2; i++) step(mk(16'h1234, 2'b00, 4'b0011, 1'b0, 2'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL test_alarm[%0d] got=%h want=%h (digits,mode,valid,ack,owner,buzz)", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_simultaneous;
        exp_t e, o;
        int n = 0;
        msg_req = 1'b1; msg_digits = 16'hC0DE; msg_mode = 2'b01; msg_valid = 4'hF;
        alarm_req = 1'b1; alarm_digits = 16'hAAAA; alarm_valid = 4'hF;
        step(mk(16'hAAAA, 2'b10, 4'hF, 1'b0, 2'd2, 1'b1));
        step(mk(16'hAAAA, 2'b10, 4'hF, 1'b0, 2'd2, 1'b1));
        step(mk(16'hAAAA, 2'b10, 4'h0, 1'b0, 2'd2, 1'b1));
        alarm_req = 1'b0;
        step(mk(16'hC0DE, 2'b01, 4'hF, 1'b1, 2'd1, 1'b0));
        msg_req = 1'b0;
        for (int i = 0; i < 3; i++) step(mk(16'hC0DE, 2'b01, 4'hF, 1'b0, 2'd1, 1'b0));
        step(mk(16'h1234, 2'b00, 4'b0011, 1'b0, 2'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL test_simultaneous[%0d] got=%h want=%h (digits,mode,valid,ack,owner,buzz)", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_msg;
        exp_t e, o;
        int n = 0;
        msg_req = 1'b1; msg_digits = 16'hC0DE; msg_mode = 2'b01; msg_valid = 4'hF;
        step(mk(16'hC0DE, 2'b01, 4'hF, 1'b1, 2'd1, 1'b0));
        msg_req = 1'b0;
        step(mk(16'hC0DE, 2'b01, 4'hF, 1'b0, 2'd1, 1'b0));
        reset = 1'b0;
        step(mk(16'h0000, 2'b00, 4'b0000, 1'b0, 2'd0, 1'b0));
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(mk(16'h1234, 2'b00, 4'b0011, 1'b0, 2'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL test_reset_mid_msg[%0d] got=%h want=%h (digits,mode,valid,ack,owner,buzz)", n, o, e);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_msg();
        test_retrigger();
        test_alarm();
        test_simultaneous();
        test_reset_mid_msg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
